// File: rtl/logic_gate_pkg.sv
// Shared constants for the logic-gate datapath and its built-in self-test:
// function-select encoding, self-test FSM states and the exhaustive vector set.
package logic_gate_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NAND  = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOT_A = 3'd6,
      OP_BUF_A = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } bist_state_e;

   localparam int unsigned BIST_VEC_CNT  = 32;
   localparam logic [4:0]  BIST_LAST_VEC = 5'(BIST_VEC_CNT - 1);

   // Truth table indexed by the vector itself {op, a, b}; one nibble per op,
   // kept deliberately separate from the gate_alu case statement.
   localparam logic [31:0] BIST_REF_LUT = 32'hC396_17E8;

   function automatic logic bist_ref_bit(input logic [4:0] vec);
      logic [31:0] lut_s;
      lut_s = BIST_REF_LUT;
      return lut_s[vec];
   endfunction

endpackage

// File: rtl/gate_alu.sv
// Combinational per-lane logic function unit selected by op.
module gate_alu
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // lane-wise function select
   always_comb begin
      y = '0;
      case (op_e'(op))
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NOT_A: y = ~a;
         OP_BUF_A: y = a;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/logic_gate_bist.sv
// Registered logic-gate unit with optional exhaustive self-test, compiled in
// only when LOGIC_GATE_BIST_EN is defined; otherwise the BIST ports are inert.
module logic_gate_bist
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             bist_start,
   input  logic             bist_inv,
   output logic             bist_done,
   output logic             bist_pass,
   output logic [5:0]       bist_err_cnt
);

   logic [2:0]       alu_op_s;
   logic [WIDTH-1:0] alu_a_s;
   logic [WIDTH-1:0] alu_b_s;
   logic [WIDTH-1:0] alu_y_s;
   logic [WIDTH-1:0] dp_y_s;
   logic             xfer_s;
   logic [WIDTH-1:0] y_r;
   logic             out_valid_r;

   gate_alu #(.WIDTH(WIDTH)) u_gate_alu (
      .op (alu_op_s),
      .a  (alu_a_s),
      .b  (alu_b_s),
      .y  (alu_y_s)
   );

   // fault injection flips lane 0 for both user and self-test results
   always_comb begin
      dp_y_s    = alu_y_s;
      dp_y_s[0] = alu_y_s[0] ^ bist_inv;
   end

   assign xfer_s = in_valid & in_ready;

`ifdef LOGIC_GATE_BIST_EN
   bist_state_e      state_r;
   bist_state_e      state_nxt_s;
   logic             sweep_s;
   logic             start_s;
   logic [4:0]       vec_cnt_r;
   logic [WIDTH-1:0] chk_res_r;
   logic [WIDTH-1:0] chk_ref_r;
   logic             chk_pend_r;
   logic             chk_last_r;
   logic             fin_r;
   logic [5:0]       err_cnt_r;
   logic             done_r;
   logic             pass_r;

   assign sweep_s = (state_r == ST_SWEEP);
   assign start_s = bist_start & ~sweep_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; SWEEP lasts exactly one cycle per vector
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bist_start) state_nxt_s = ST_SWEEP;
            else            state_nxt_s = ST_IDLE;
         end
         ST_SWEEP: begin
            if (vec_cnt_r == BIST_LAST_VEC) state_nxt_s = ST_DONE;
            else                            state_nxt_s = ST_SWEEP;
         end
         ST_DONE: begin
            if (bist_start) state_nxt_s = ST_SWEEP;
            else            state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // datapath operand select: vector counter owns the ALU during SWEEP
   always_comb begin
      alu_op_s = op;
      alu_a_s  = a;
      alu_b_s  = b;
      if (sweep_s) begin
         alu_op_s = vec_cnt_r[4:2];
         alu_a_s  = {WIDTH{vec_cnt_r[1]}};
         alu_b_s  = {WIDTH{vec_cnt_r[0]}};
      end else begin
         alu_op_s = op;
         alu_a_s  = a;
         alu_b_s  = b;
      end
   end

   assign in_ready = ~sweep_s;

   // vector counter and issue stage: capture result and reference together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt_r  <= 5'd0;
         chk_res_r  <= '0;
         chk_ref_r  <= '0;
         chk_pend_r <= 1'b0;
         chk_last_r <= 1'b0;
      end else if (start_s) begin
         vec_cnt_r  <= 5'd0;
         chk_pend_r <= 1'b0;
         chk_last_r <= 1'b0;
      end else if (sweep_s) begin
         chk_res_r  <= dp_y_s;
         chk_ref_r  <= {WIDTH{bist_ref_bit(vec_cnt_r)}};
         chk_pend_r <= 1'b1;
         chk_last_r <= (vec_cnt_r == BIST_LAST_VEC);
         vec_cnt_r  <= vec_cnt_r + 5'd1;
      end else begin
         chk_pend_r <= 1'b0;
         chk_last_r <= 1'b0;
      end
   end

   // compare stage and sticky status; done follows the final compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= 6'd0;
         fin_r     <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
      end else if (start_s) begin
         err_cnt_r <= 6'd0;
         fin_r     <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
      end else begin
         if (chk_pend_r && (chk_res_r != chk_ref_r)) begin
            err_cnt_r <= err_cnt_r + 6'd1;
         end
         fin_r <= chk_last_r;
         if (fin_r) begin
            done_r <= 1'b1;
            pass_r <= (err_cnt_r == 6'd0);
         end
      end
   end

   assign bist_done    = done_r;
   assign bist_pass    = pass_r;
   assign bist_err_cnt = err_cnt_r;
`else
   logic unused_s;

   assign alu_op_s     = op;
   assign alu_a_s      = a;
   assign alu_b_s      = b;
   assign in_ready     = 1'b1;
   assign bist_done    = 1'b0;
   assign bist_pass    = 1'b0;
   assign bist_err_cnt = 6'd0;
   assign unused_s     = &{1'b0, bist_start};
`endif

   // user result register: one-cycle latency, y holds between transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_r         <= '0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= xfer_s;
         if (xfer_s) begin
            y_r <= dp_y_s;
         end
      end
   end

   assign y         = y_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_logic_gate_bist.sv
// Self-checking bench for logic_gate_bist; self-test checks are built only
// when LOGIC_GATE_BIST_EN is defined, otherwise the inert BIST ports are checked.
module tb_logic_gate_bist;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             bist_start;
   logic             bist_inv;
   logic             bist_done;
   logic             bist_pass;
   logic [5:0]       bist_err_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_y;
   logic             exp_ov;

   logic_gate_bist #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a),
      .b            (b),
      .op           (op),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .y            (y),
      .out_valid    (out_valid),
      .bist_start   (bist_start),
      .bist_inv     (bist_inv),
      .bist_done    (bist_done),
      .bist_pass    (bist_pass),
      .bist_err_cnt (bist_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] model(input logic [2:0] f, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z, input logic inv);
      logic [WIDTH-1:0] r;
      case (f)
         3'd0:    r = x & z;
         3'd1:    r = x | z;
         3'd2:    r = ~(x & z);
         3'd3:    r = ~(x | z);
         3'd4:    r = x ^ z;
         3'd5:    r = ~(x ^ z);
         3'd6:    r = ~x;
         default: r = x;
      endcase
      r[0] = r[0] ^ inv;
      return r;
   endfunction

   // Mismatch count the self-test should report: walk all 32 exhaustive vectors.
   function automatic int expected_err(input logic inv);
      int cnt = 0;
      for (int v = 0; v < 32; v++) begin
         logic [2:0]       f  = 3'(v / 4);
         logic [WIDTH-1:0] av = ((v / 2) % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
         logic [WIDTH-1:0] bv = (v % 2 == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
         if (model(f, av, bv, inv) != model(f, av, bv, 1'b0)) cnt++;
      end
      return cnt;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

`ifdef LOGIC_GATE_BIST_EN
   // One full self-test run, entered #1 after an edge with the block idle.
   task automatic run_bist(input logic inv, input int exp_err);
      logic [WIDTH-1:0] y_hold;
      bist_inv   = inv;
      bist_start = 1'b1;
      in_valid   = 1'b1;
      op         = 3'($urandom_range(0, 7));
      a          = WIDTH'($urandom);
      b          = WIDTH'($urandom);
      y_hold     = model(op, a, b, inv);
      tick();
      bist_start = 1'b0;
      chk("start_cycle_ov", 32'(out_valid), 32'd1);
      chk("start_cycle_y", 32'(y), 32'(y_hold));
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) begin
            tick();
            chk("sweep_ov", 32'(out_valid), 32'd0);
            chk("sweep_y_hold", 32'(y), 32'(y_hold));
         end
         chk("sweep_in_ready", 32'(in_ready), (k >= 32) ? 32'd1 : 32'd0);
         chk("sweep_done", 32'(bist_done), (k >= 34) ? 32'd1 : 32'd0);
         chk("sweep_pass", 32'(bist_pass), (k >= 34 && exp_err == 0) ? 32'd1 : 32'd0);
         if (k == 40) chk("err_cnt", 32'(bist_err_cnt), 32'(exp_err));
         in_valid   = (k < 31);
         op         = 3'($urandom_range(0, 7));
         a          = WIDTH'($urandom);
         b          = WIDTH'($urandom);
         bist_start = (k == 5);
      end
      in_valid = 1'b0;
      bist_inv = 1'b0;
   endtask
`endif

   initial begin
      logic [7:0] tbl [8];
      tbl = '{8'h0A, 8'hAF, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'h55, 8'hAA};

      rst_n      = 1'b0;
      a          = '0;
      b          = '0;
      op         = 3'd0;
      in_valid   = 1'b0;
      bist_start = 1'b0;
      bist_inv   = 1'b0;
      tick();
      tick();
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_done", 32'(bist_done), 32'd0);
      chk("rst_pass", 32'(bist_pass), 32'd0);
      chk("rst_err", 32'(bist_err_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      // NAND example
      op = 3'd2; a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
      tick();
      chk("nand_y", 32'(y), 32'h3F);
      chk("nand_ov", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("idle_ov", 32'(out_valid), 32'd0);
      chk("idle_y_hold", 32'(y), 32'h3F);

      // all eight functions back to back
      for (int i = 0; i < 8; i++) begin
         op = 3'(i); a = 8'hAA; b = 8'h0F; in_valid = 1'b1;
         tick();
         chk($sformatf("op%0d_y", i), 32'(y), 32'(tbl[i]));
         chk($sformatf("op%0d_ov", i), 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      tick();

      // randomized user traffic, including fault injection on lane 0
      exp_y = 8'hAA;
      for (int i = 0; i < 60; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         op       = 3'($urandom_range(0, 7));
         a        = WIDTH'($urandom);
         b        = WIDTH'($urandom);
         bist_inv = 1'($urandom_range(0, 1));
         exp_ov   = in_valid;
         if (in_valid) exp_y = model(op, a, b, bist_inv);
         tick();
         chk("rand_ov", 32'(out_valid), 32'(exp_ov));
         chk("rand_y", 32'(y), 32'(exp_y));
      end
      in_valid = 1'b0;
      bist_inv = 1'b0;
      tick();

`ifdef LOGIC_GATE_BIST_EN
      run_bist(1'b0, expected_err(1'b0));
      tick();
      chk("done_sticky", 32'(bist_done), 32'd1);
      run_bist(1'b1, expected_err(1'b1));
      tick();

      // reset in the middle of a sweep
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("mid_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_y", 32'(y), 32'd0);
      chk("midrst_ov", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_done", 32'(bist_done), 32'd0);
      chk("midrst_pass", 32'(bist_pass), 32'd0);
      chk("midrst_err", 32'(bist_err_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      chk("postrst_err", 32'(bist_err_cnt), 32'd0);
      run_bist(1'b0, expected_err(1'b0));
`else
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         chk("nobist_in_ready", 32'(in_ready), 32'd1);
         chk("nobist_done", 32'(bist_done), 32'd0);
         chk("nobist_pass", 32'(bist_pass), 32'd0);
         chk("nobist_err", 32'(bist_err_cnt), 32'd0);
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_gate_bist.md
LOGIC_GATE_BIST -- requirements
Module: logic_gate_bist

Interface
REQ-001 Parameter WIDTH, default 8, lane count of operands and result; SHALL be >= 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 op  input  3  function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 BUF_A.
REQ-007 in_valid  input  1  user operands valid.
REQ-008 in_ready  output  1  block accepts user operands.
REQ-009 y  output  WIDTH  registered result.
REQ-010 out_valid  output  1  y holds a user result.
REQ-011 bist_start  input  1  single-cycle self-test request.
REQ-012 bist_inv  input  1  fault injection: inverts lane 0 of the datapath result when 1.
REQ-013 bist_done  output  1  self-test complete (level).
REQ-014 bist_pass  output  1  self-test had zero mismatches (valid when bist_done=1).
REQ-015 bist_err_cnt  output  6  mismatch count of last/current test.

Function
REQ-016 The datapath SHALL compute y per lane from op; bist_inv SHALL apply to both user and BIST results.
REQ-017 The user transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; y and out_valid=1 SHALL appear on the next cycle (latency 1). out_valid SHALL be 0 otherwise, and y SHALL hold its last value.
REQ-018 No output backpressure; every result SHALL be presented for exactly one cycle.
REQ-019 FSM states: IDLE, SWEEP, DONE. IDLE->SWEEP on bist_start; SWEEP->DONE after the last compare; DONE->SWEEP on bist_start.
REQ-020 in_ready SHALL be 1 in IDLE and DONE, and 0 in SWEEP; in_valid in SWEEP SHALL be ignored.
REQ-021 On entry to SWEEP, bist_err_cnt, bist_done and bist_pass SHALL be cleared.
REQ-022 A 5-bit vector counter SHALL issue 32 vectors on consecutive cycles: op = cnt[4:2], a = replicate(cnt[1]), b = replicate(cnt[0]).
REQ-023 Each BIST result SHALL be compared one cycle after issue against an internal reference of the same function; any lane differing SHALL increment bist_err_cnt by 1 for that vector.
REQ-024 Timing: bist_start sampled at edge t -> vectors issued at t+1..t+32 -> compares at t+2..t+33 -> bist_done=1 from t+34 until the next bist_start or reset.
REQ-025 bist_pass SHALL be (bist_err_cnt==0) while bist_done=1, and 0 otherwise.
REQ-026 bist_start during SWEEP SHALL be ignored. A user transfer completing on the bist_start cycle SHALL still produce its out_valid on the next cycle.
REQ-027 BIST results SHALL NOT assert out_valid.

Reset
REQ-028 On rst_n=0, regardless of state: FSM to IDLE; y=0, out_valid=0, bist_done=0, bist_pass=0, bist_err_cnt=0, counter=0; in_ready=1 after reset.
REQ-029 Reset during SWEEP SHALL abandon the test with no residual count.

Configuration
REQ-030 Macro LOGIC_GATE_BIST_EN: when defined, the FSM, counter, reference and checker SHALL be compiled in as specified above.
REQ-031 When LOGIC_GATE_BIST_EN is undefined, all ports SHALL remain present. bist_start SHALL be ignored, in_ready SHALL be tied to 1, and bist_done, bist_pass and bist_err_cnt SHALL be tied to 0.

Structure
REQ-032 Package logic_gate_pkg SHALL hold the op encoding constants, the FSM state encoding and the vector count constant (32).
REQ-033 The combinational per-lane function SHALL be sub-module gate_alu (parameter WIDTH). It SHALL be instantiated once for the datapath; the BIST reference SHALL be an independent expression, not a second gate_alu.

Verification
REQ-034 WIDTH=8, op=2, a=8'hF0, b=8'hCC, in_valid=1 -> next cycle y=8'h3F, out_valid=1.
REQ-035 All 8 ops with a=8'hAA, b=8'h0F -> y = 0A, AF, F5, 50, A5, 5A, 55, AA respectively.
REQ-036 bist_start pulse, bist_inv=0 -> in_ready=0 for 32 cycles; bist_done=1 at t+34; bist_pass=1; bist_err_cnt=0.
REQ-037 bist_start pulse, bist_inv=1 -> bist_done=1 at t+34; bist_pass=0; bist_err_cnt=32.
REQ-038 rst_n low at t+10 of a BIST run -> all outputs 0 and in_ready=1. A following bist_start pulse with bist_inv=0 -> pass.
REQ-039 With LOGIC_GATE_BIST_EN undefined, bist_start pulse -> in_ready stays 1, and bist_done, bist_pass and bist_err_cnt stay 0.
